// File: rtl/key_debouncer.sv
// Multi-channel push-button debouncer.
// Each key passes through a 2-flop synchroniser. It is then sampled on a shared
// prescaler strobe. A new level is accepted only after STABLE consecutive samples
// all disagree with the current debounced level. One-clock press and release
// pulses accompany every accepted change.
// The release pulse port is called `rel` because `release` is a reserved word.
module key_debouncer #(
  parameter int CH         = 6,
  parameter int DIV_WIDTH  = 8,
  parameter int STABLE     = 4,
  parameter int ACTIVE_LOW = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] keyin,
  output logic [CH-1:0] keyout,
  output logic [CH-1:0] press,
  output logic [CH-1:0] rel,
  output logic          tick
);

  localparam int CNT_W = $clog2(STABLE + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE - 1);
  localparam logic [CH-1:0] INV_MASK = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [CH-1:0]        norm;
  logic [CH-1:0]        sync_q1;
  logic [CH-1:0]        sync_q2;
  logic [DIV_WIDTH-1:0] div_cnt;
  logic [DIV_WIDTH-1:0] div_next;
  logic [CNT_W-1:0]     stab_cnt [CH];
  logic [CNT_W-1:0]     cnt_next [CH];
  logic [CH-1:0]        key_next;
  logic [CH-1:0]        press_next;
  logic [CH-1:0]        rel_next;

  // Polarity is fixed up before the synchroniser, so everything downstream sees 1 = pressed.
  assign norm     = keyin ^ INV_MASK;
  assign div_next = div_cnt + 1'b1;

  // Two-stage synchroniser for the asynchronous key inputs.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state uses non-blocking assignments, so sync_q2 takes the old sync_q1
    // rather than the value just written, and the two flops form a real two-stage chain.
    if (rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= norm;
      sync_q2 <= sync_q1;
    end
  end

  // Free-running prescaler. tick is registered and is high while the counter holds all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      div_cnt <= div_next;
      tick    <= (div_next == '1);
    end
  end

  // Per-channel acceptance decision. The state moves only on the edge that follows a tick.
  always_comb begin
    // NOTE: every output of this block gets a default before any branch, so no path
    // leaves a value unassigned and no latch is inferred.
    key_next   = keyout;
    press_next = '0;
    rel_next   = '0;
    for (int i = 0; i < CH; i++) begin
      cnt_next[i] = stab_cnt[i];
      if (tick) begin
        if (sync_q2[i] == keyout[i]) begin
          // Matching sample (steady level or bounce): restart the run.
          cnt_next[i] = '0;
        end else if (stab_cnt[i] == LAST) begin
          // STABLE-th consecutive differing sample: accept the new level.
          cnt_next[i]   = '0;
          key_next[i]   = sync_q2[i];
          press_next[i] = sync_q2[i];
          rel_next[i]   = ~sync_q2[i];
        end else begin
          cnt_next[i] = stab_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Debounced level, stability counters and the single-cycle edge pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      keyout <= '0;
      press  <= '0;
      rel    <= '0;
      // NOTE: the counter array is a handful of flops, not a RAM, so every entry is
      // cleared on reset. A reset counter must never be left holding stale run lengths.
      for (int i = 0; i < CH; i++) begin
        stab_cnt[i] <= '0;
      end
    end else begin
      keyout <= key_next;
      press  <= press_next;
      rel    <= rel_next;
      for (int i = 0; i < CH; i++) begin
        stab_cnt[i] <= cnt_next[i];
      end
    end
  end

endmodule

// File: tb/tb_key_debouncer.sv
// Testbench for key_debouncer.
// Two instances are driven: an active-high one and an active-low one. Both are
// compared every cycle against a sample-history reference model. Directed
// scenarios come first, then randomised key activity with occasional resets.
module tb_key_debouncer;

  localparam int CH  = 6;
  localparam int DW  = 2;
  localparam int ST  = 3;
  localparam int PER = 1 << DW;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] keyin;
  logic [CH-1:0] keyin_al;
  logic [CH-1:0] keyout0, press0, rel0;
  logic [CH-1:0] keyout1, press1, rel1;
  logic          tick0, tick1;

  always #5 clk = ~clk;

  key_debouncer #(.CH(CH), .DIV_WIDTH(DW), .STABLE(ST), .ACTIVE_LOW(0)) dut (
    .clk    (clk),
    .rst    (rst),
    .keyin  (keyin),
    .keyout (keyout0),
    .press  (press0),
    .rel    (rel0),
    .tick   (tick0)
  );

  key_debouncer #(.CH(CH), .DIV_WIDTH(DW), .STABLE(ST), .ACTIVE_LOW(1)) dut_al (
    .clk    (clk),
    .rst    (rst),
    .keyin  (keyin_al),
    .keyout (keyout1),
    .press  (press1),
    .rel    (rel1),
    .tick   (tick1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Single checking point: counts and reports every comparison.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Sampling ticks fall on clock counts PER-1, 2*PER-1, ... after reset. The state changes
  // on the edge that follows each tick, using the key value that was seen two edges earlier.
  // A channel flips once its last ST samples since the previous flip all disagree with its level.
  int unsigned   edge_cnt;
  logic [CH-1:0] n_d1 [2];
  logic [CH-1:0] n_d2 [2];
  logic [CH-1:0] m_key [2];
  logic [CH-1:0] m_press [2];
  logic [CH-1:0] m_rel [2];
  logic          m_tick;
  logic [ST-1:0] win [2*CH];
  int            fill [2*CH];

  task automatic model_reset();
    edge_cnt = 0;
    m_tick   = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_d1[k] = '0; n_d2[k] = '0;
      m_key[k] = '0; m_press[k] = '0; m_rel[k] = '0;
    end
    for (int j = 0; j < 2*CH; j++) begin
      win[j] = '0; fill[j] = 0;
    end
  endtask

  task automatic model_step();
    logic [CH-1:0] n_now [2];
    logic [ST-1:0] ones;
    int            idx;
    logic          s;
    ones     = '1;
    n_now[0] = keyin;
    n_now[1] = ~keyin_al;
    if (rst) begin
      model_reset();
      return;
    end
    edge_cnt++;
    for (int k = 0; k < 2; k++) begin
      m_press[k] = '0;
      m_rel[k]   = '0;
    end
    if (edge_cnt % PER == 0) begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < CH; i++) begin
          idx      = k*CH + i;
          s        = n_d2[k][i];
          win[idx] = {win[idx][ST-2:0], s};
          if (fill[idx] < ST) fill[idx]++;
          if (fill[idx] == ST && win[idx] == (m_key[k][i] ? '0 : ones)) begin
            m_key[k][i]   = s;
            m_press[k][i] = s;
            m_rel[k][i]   = ~s;
            fill[idx]     = 0;
          end
        end
      end
    end
    m_tick = ((edge_cnt % PER) == PER - 1);
    for (int k = 0; k < 2; k++) begin
      n_d2[k] = n_d1[k];
      n_d1[k] = n_now[k];
    end
  endtask

  // Pulse bookkeeping, taken from what the DUTs actually emit.
  int            pc [2];
  int            rc [2];
  logic [CH-1:0] lp [2];
  logic [CH-1:0] lr [2];

  task automatic clear_counts();
    for (int k = 0; k < 2; k++) begin
      pc[k] = 0; rc[k] = 0; lp[k] = '0; lr[k] = '0;
    end
  endtask

  task automatic compare();
    check("keyout",     32'(keyout0), 32'(m_key[0]));
    check("press",      32'(press0),  32'(m_press[0]));
    check("release",    32'(rel0),    32'(m_rel[0]));
    check("tick",       32'(tick0),   32'(m_tick));
    check("al_keyout",  32'(keyout1), 32'(m_key[1]));
    check("al_press",   32'(press1),  32'(m_press[1]));
    check("al_release", 32'(rel1),    32'(m_rel[1]));
    check("al_tick",    32'(tick1),   32'(m_tick));
    if (press0 != '0) begin pc[0]++; lp[0] = press0; end
    if (rel0   != '0) begin rc[0]++; lr[0] = rel0;   end
    if (press1 != '0) begin pc[1]++; lp[1] = press1; end
    if (rel1   != '0) begin rc[1]++; lr[1] = rel1;   end
  endtask

  // One clock: the model advances on the rising edge, and outputs are checked on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  // Asynchronous reset pulse of one clock, asserted mid low phase.
  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    check("async_rst_keyout", 32'(keyout0), 32'h0);
    check("async_rst_press",  32'(press0),  32'h0);
    check("async_rst_al_key", 32'(keyout1), 32'h0);
    run(1);
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b0;
    keyin    = '1;
    keyin_al = '1;
    model_reset();
    clear_counts();
    #1 rst = 1'b1;
    #1;
    check("rst_keyout", 32'(keyout0), 32'h0);
    check("rst_press",  32'(press0),  32'h0);
    check("rst_rel",    32'(rel0),    32'h0);
    check("rst_tick",   32'(tick0),   32'h0);
    run(3);

    // Idle after reset: ticks only, no pulses.
    keyin = '0;
    rst   = 1'b0;
    clear_counts();
    run(16);
    check("idle_press_count", 32'(pc[0]), 32'd0);

    // Clean press then release on channel 0.
    keyin = 6'b000001;
    run(20);
    check("ch0_press_count", 32'(pc[0]), 32'd1);
    check("ch0_press_value", 32'(lp[0]), 32'h01);
    check("ch0_keyout",      32'(keyout0), 32'h01);
    keyin = '0;
    run(20);
    check("ch0_rel_count", 32'(rc[0]), 32'd1);
    check("ch0_rel_value", 32'(lr[0]), 32'h01);

    // Bounce on channel 2: samples 1,1,0,1,1,1 (each level held one tick period).
    clear_counts();
    keyin = 6'b000100; run(PER);
    keyin = 6'b000100; run(PER);
    keyin = 6'b000000; run(PER);
    keyin = 6'b000100; run(PER);
    keyin = 6'b000100; run(PER);
    check("bounce_held_low", 32'(keyout0[2]), 32'h0);
    run(PER + 3);
    check("bounce_accepted",    32'(keyout0[2]), 32'h1);
    check("bounce_press_count", 32'(pc[0]), 32'd1);
    keyin = '0;
    run(20);

    // Simultaneous acceptance on channels 0 and 5.
    clear_counts();
    keyin = 6'b100001;
    run(20);
    check("simul_press_cycles", 32'(pc[0]), 32'd1);
    check("simul_press_value",  32'(lp[0]), 32'h21);
    check("simul_keyout",       32'(keyout0), 32'h21);
    keyin = '0;
    run(20);

    // Reset in the middle of a stability count on channel 3.
    clear_counts();
    keyin = 6'b001000;
    run(2*PER);
    pulse_reset();
    check("midrst_no_pulse", 32'(pc[0]), 32'd0);
    run(2);
    check("midrst_keyout_low", 32'(keyout0), 32'h0);
    run(20);
    check("midrst_press_count", 32'(pc[0]), 32'd1);
    check("midrst_press_value", 32'(lp[0]), 32'h08);
    keyin = '0;
    run(20);

    // Active-low instance: key 1 pulled low, then restored.
    clear_counts();
    keyin_al = 6'b111101;
    run(20);
    check("al_keyout_pressed", 32'(keyout1), 32'h02);
    check("al_press_count",    32'(pc[1]), 32'd1);
    check("al_press_value",    32'(lp[1]), 32'h02);
    keyin_al = '1;
    run(20);
    check("al_rel_count", 32'(rc[1]), 32'd1);
    check("al_rel_value", 32'(lr[1]), 32'h02);
    check("al_keyout_idle", 32'(keyout1), 32'h0);

    // Randomised activity with occasional resets.
    for (int t = 0; t < 250; t++) begin
      keyin    = CH'($urandom);
      keyin_al = CH'($urandom);
      if ($urandom_range(0, 24) == 0) pulse_reset();
      run($urandom_range(1, 16));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
